// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction-memory fetch request handshake
interface fetch_ctrl_if #(
  parameter int PC_WIDTH = 32
);
  logic                imem_req_valid_out;
  logic                imem_req_ready_in;
  logic [PC_WIDTH-1:0] imem_req_addr_out;

  modport master (
    output imem_req_valid_out,
    output imem_req_addr_out,
    input  imem_req_ready_in
  );

  modport slave (
    input  imem_req_valid_out,
    input  imem_req_addr_out,
    output imem_req_ready_in
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch sequencer: PC load control, IMEM request, redirect handling
module fetch_ctrl #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_WIDTH-1:0]  pc_in,
  input  logic                 stall_in,
  input  logic                 br_taken_in,
  input  logic [PC_WIDTH-1:0]  br_target_in,
  input  logic                 jump_in,
  input  logic [PC_WIDTH-1:0]  jump_target_in,
  fetch_ctrl_if.master         imem,
  output logic                 pc_en_out,
  output logic                 pc_sel_out,
  output logic [PC_WIDTH-1:0]  pc_new_out,
  output logic                 flush_out,
  output logic                 inst_valid_out,
  output logic [CNT_WIDTH-1:0] redir_cnt_out
);

  typedef enum logic [1:0] {BOOT, RUN, REDIR_WAIT} state_t;

  state_t                state_q, state_d;
  logic                  hold_q, hold_d;
  logic [PC_WIDTH-1:0]   redir_q, redir_d;
  logic                  fire_q, fire_d;
  logic                  kill_q, kill_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  valid, fire, killed, redir;
  logic                  pc_en, pc_sel, flush;
  logic [PC_WIDTH-1:0]   pc_new, target;

  assign redir  = br_taken_in | jump_in;
  assign target = br_taken_in ? br_target_in : jump_target_in;

  always_comb begin
    state_d = state_q;
    redir_d = redir_q;
    cnt_d   = cnt_q;
    valid   = 1'b0;
    pc_en   = 1'b0;
    pc_sel  = 1'b0;
    pc_new  = '0;
    flush   = 1'b0;
    killed  = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        // A request left hanging without ready must be kept alive through stalls.
        valid = ~stall_in | hold_q;
        if (redir) begin
          flush = 1'b1;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (!valid || imem.imem_req_ready_in) begin
            pc_en  = 1'b1;
            pc_sel = 1'b1;
            pc_new = target;
            killed = 1'b1;
          end else begin
            redir_d = target;
            state_d = REDIR_WAIT;
          end
        end else if (imem.imem_req_ready_in && valid) begin
          pc_en = 1'b1;
        end
      end
      REDIR_WAIT: begin
        valid = 1'b1;
        // Only an older (EX-stage) branch can supersede the pending target.
        if (br_taken_in) begin
          redir_d = br_target_in;
          flush   = 1'b1;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
        end
        if (imem.imem_req_ready_in) begin
          pc_en   = 1'b1;
          pc_sel  = 1'b1;
          pc_new  = br_taken_in ? br_target_in : redir_q;
          killed  = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    if (rst) begin
      valid  = 1'b0;
      pc_en  = 1'b0;
      pc_sel = 1'b0;
      pc_new = '0;
      flush  = 1'b0;
    end
  end

  assign fire   = valid & imem.imem_req_ready_in;
  assign hold_d = valid & ~imem.imem_req_ready_in;
  assign fire_d = fire;
  assign kill_d = fire & killed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      hold_q  <= 1'b0;
      redir_q <= '0;
      fire_q  <= 1'b0;
      kill_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      redir_q <= redir_d;
      fire_q  <= fire_d;
      kill_q  <= kill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem.imem_req_valid_out = valid;
  assign imem.imem_req_addr_out  = pc_in;
  assign pc_en_out      = pc_en;
  assign pc_sel_out     = pc_sel;
  assign pc_new_out     = pc_new;
  assign flush_out      = flush;
  assign inst_valid_out = fire_q & ~kill_q & ~rst;
  assign redir_cnt_out  = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed vector bench for fetch_ctrl with a PC register model
module tb_fetch_ctrl;
  localparam int PW = 32;
  localparam int CW = 4;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] brt;
    logic        jmp;
    logic [31:0] jmpt;
    logic        rdy;
    logic        ev;
    logic [31:0] ea;
    logic        een;
    logic        esel;
    logic [31:0] enew;
    logic        efl;
    logic        einst;
    logic [3:0]  ecnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] pc_q;
  logic          stall = 1'b0;
  logic          br = 1'b0;
  logic [PW-1:0] brt = '0;
  logic          jmp = 1'b0;
  logic [PW-1:0] jmpt = '0;
  logic          pc_en, pc_sel, flush, inst_valid;
  logic [PW-1:0] pc_new;
  logic [CW-1:0] cnt;
  int            total = 0;
  int            bad = 0;
  vec_t          vecs[$];

  fetch_ctrl_if #(.PC_WIDTH(PW)) bus ();

  fetch_ctrl #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_q),
    .stall_in       (stall),
    .br_taken_in    (br),
    .br_target_in   (brt),
    .jump_in        (jmp),
    .jump_target_in (jmpt),
    .imem           (bus.master),
    .pc_en_out      (pc_en),
    .pc_sel_out     (pc_sel),
    .pc_new_out     (pc_new),
    .flush_out      (flush),
    .inst_valid_out (inst_valid),
    .redir_cnt_out  (cnt)
  );

  always #5 clk = ~clk;

  // PC register the controller drives
  always @(posedge clk) begin
    if (rst) pc_q <= '0;
    else if (pc_en) pc_q <= pc_sel ? pc_new : pc_q + 32'd4;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt, input logic rd);
    @(posedge clk);
    #1;
    rst = r; stall = s; br = b; brt = bt; jmp = j; jmpt = jt;
    bus.imem_req_ready_in = rd;
    @(negedge clk);
  endtask

  task automatic check_all(input string p, input logic ev, input logic [31:0] ea, input logic een,
                           input logic esel, input logic [31:0] enew, input logic efl,
                           input logic einst, input logic [3:0] ecnt);
    chk({p, ".valid"}, 32'(bus.imem_req_valid_out), 32'(ev));
    chk({p, ".addr"},  bus.imem_req_addr_out, ea);
    chk({p, ".pc_en"}, 32'(pc_en), 32'(een));
    chk({p, ".sel"},   32'(pc_sel), 32'(esel));
    chk({p, ".new"},   pc_new, enew);
    chk({p, ".flush"}, 32'(flush), 32'(efl));
    chk({p, ".inst"},  32'(inst_valid), 32'(einst));
    chk({p, ".cnt"},   32'(cnt), 32'(ecnt));
  endtask

  task automatic add(input logic s, input logic b, input logic [31:0] bt, input logic j,
                     input logic [31:0] jt, input logic rd, input logic ev, input logic [31:0] ea,
                     input logic een, input logic esel, input logic [31:0] enew, input logic efl,
                     input logic einst, input logic [3:0] ecnt);
    vecs.push_back('{s, b, bt, j, jt, rd, ev, ea, een, esel, enew, efl, einst, ecnt});
  endtask

  initial begin
    bus.imem_req_ready_in = 1'b0;
    //   stall br brt     jmp jmpt    rdy | v  addr    en sel new     fl in cnt
    add(0, 1, 32'h999, 0, 32'h0,   1,   0, 32'h0,   0, 0, 32'h0,   0, 0, 0); // BOOT ignores br
    add(0, 0, 32'h0,   0, 32'h0,   1,   1, 32'h0,   1, 0, 32'h0,   0, 0, 0);
    add(0, 0, 32'h0,   0, 32'h0,   1,   1, 32'h4,   1, 0, 32'h0,   0, 1, 0);
    add(1, 0, 32'h0,   0, 32'h0,   1,   0, 32'h8,   0, 0, 32'h0,   0, 1, 0);
    add(1, 0, 32'h0,   0, 32'h0,   1,   0, 32'h8,   0, 0, 32'h0,   0, 0, 0);
    add(1, 0, 32'h0,   0, 32'h0,   1,   0, 32'h8,   0, 0, 32'h0,   0, 0, 0);
    add(0, 0, 32'h0,   0, 32'h0,   1,   1, 32'h8,   1, 0, 32'h0,   0, 0, 0);
    add(0, 0, 32'h0,   0, 32'h0,   1,   1, 32'hC,   1, 0, 32'h0,   0, 1, 0);
    add(0, 0, 32'h0,   0, 32'h0,   0,   1, 32'h10,  0, 0, 32'h0,   0, 1, 0);
    add(1, 0, 32'h0,   0, 32'h0,   0,   1, 32'h10,  0, 0, 32'h0,   0, 0, 0); // held through stall
    add(1, 0, 32'h0,   0, 32'h0,   1,   1, 32'h10,  1, 0, 32'h0,   0, 0, 0);
    add(0, 0, 32'h0,   0, 32'h0,   1,   1, 32'h14,  1, 0, 32'h0,   0, 1, 0);
    add(0, 0, 32'h0,   0, 32'h0,   1,   1, 32'h18,  1, 0, 32'h0,   0, 1, 0);
    add(0, 0, 32'h0,   0, 32'h0,   1,   1, 32'h1C,  1, 0, 32'h0,   0, 1, 0);
    add(0, 1, 32'h100, 0, 32'h0,   1,   1, 32'h20,  1, 1, 32'h100, 1, 1, 0);
    add(0, 0, 32'h0,   0, 32'h0,   1,   1, 32'h100, 1, 0, 32'h0,   0, 0, 1); // 0x20 killed
    add(0, 0, 32'h0,   1, 32'h40,  0,   1, 32'h104, 0, 0, 32'h0,   1, 1, 1);
    add(0, 1, 32'h80,  0, 32'h0,   0,   1, 32'h104, 0, 0, 32'h0,   1, 0, 2);
    add(0, 0, 32'h0,   0, 32'h0,   1,   1, 32'h104, 1, 1, 32'h80,  0, 0, 3);
    add(0, 0, 32'h0,   0, 32'h0,   1,   1, 32'h80,  1, 0, 32'h0,   0, 0, 3);
    add(0, 0, 32'h0,   0, 32'h0,   1,   1, 32'h84,  1, 0, 32'h0,   0, 1, 3);
    add(0, 1, 32'h200, 1, 32'h300, 1,   1, 32'h88,  1, 1, 32'h200, 1, 1, 3);
    add(0, 0, 32'h0,   0, 32'h0,   1,   1, 32'h200, 1, 0, 32'h0,   0, 0, 4);
    add(1, 0, 32'h0,   1, 32'h400, 1,   0, 32'h204, 1, 1, 32'h400, 1, 1, 4);
    add(0, 0, 32'h0,   0, 32'h0,   1,   1, 32'h400, 1, 0, 32'h0,   0, 0, 5);
    add(0, 1, 32'h500, 0, 32'h0,   0,   1, 32'h404, 0, 0, 32'h0,   1, 1, 5);
    add(0, 0, 32'h0,   1, 32'h600, 1,   1, 32'h404, 1, 1, 32'h500, 0, 0, 6);
    add(0, 0, 32'h0,   0, 32'h0,   1,   1, 32'h500, 1, 0, 32'h0,   0, 0, 6);
    add(0, 0, 32'h0,   1, 32'h700, 0,   1, 32'h504, 0, 0, 32'h0,   1, 1, 6);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset", 0, 32'h0, 0, 0, 32'h0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(0, vecs[i].stall, vecs[i].br, vecs[i].brt, vecs[i].jmp, vecs[i].jmpt, vecs[i].rdy);
      check_all($sformatf("v%0d", i), vecs[i].ev, vecs[i].ea, vecs[i].een, vecs[i].esel,
                vecs[i].enew, vecs[i].efl, vecs[i].einst, vecs[i].ecnt);
    end

    // reset while a redirect is pending in REDIR_WAIT
    drive(1, 0, 0, 32'h0, 0, 32'h0, 1);
    check_all("rst_rw", 0, 32'h504, 0, 0, 32'h0, 0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
    check_all("rst_boot", 0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
    check_all("rst_run", 1, 32'h0, 1, 0, 32'h0, 0, 0, 0);

    // counter wrap
    for (int i = 0; i < 15; i++) begin
      drive(0, 0, 1, 32'h1000 + 32'(i) * 32'h10, 0, 32'h0, 1);
      chk($sformatf("wrap_cnt%0d", i), 32'(cnt), 32'(i));
      chk($sformatf("wrap_new%0d", i), pc_new, 32'h1000 + 32'(i) * 32'h10);
    end
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
    chk("cnt_full", 32'(cnt), 32'hF);
    chk("pc_after_br", pc_q, 32'h10E0);
    drive(0, 0, 1, 32'h2000, 0, 32'h0, 1);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
    chk("cnt_wrap", 32'(cnt), 32'h0);
    chk("pc_wrap", pc_q, 32'h2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
